// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and default widths for the carry-save accumulator
package csa_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_WIDTH = 24;
  localparam int DEF_CNT_WIDTH = 8;
endpackage

// File: rtl/csa_if.sv
// csa_if: operand stream in, framed result out
interface csa_if #(
  parameter int WIDTH = csa_pkg::DEF_WIDTH,
  parameter int ACC_WIDTH = csa_pkg::DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = csa_pkg::DEF_CNT_WIDTH
) ();
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic out_of;
  logic [CNT_WIDTH-1:0] out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_sum, out_of, out_count
  );
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_of, out_count
  );
endinterface

// File: rtl/csa_accumulator_row.sv
// csa_row: one 3:2 compression row, carries returned unshifted
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);
  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .c(c[i]), .s(s[i]), .co(co[i]));
  end
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save multi-operand accumulator with a single resolving add per frame
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  csa_if.slave bus
);
  state_t state;
  logic [ACC_WIDTH-1:0] sum_r, carry_r, row_s, row_co, ext, out_sum_r;
  logic [ACC_WIDTH:0] total;
  logic [CNT_WIDTH-1:0] cnt_r, out_count_r;
  logic sticky_of, out_of_r, in_ready_r, out_valid_r;
  assign ext = {{(ACC_WIDTH-WIDTH){1'b0}}, bus.in_data};
  csa_row #(.W(ACC_WIDTH)) u_row (.a(sum_r), .b(carry_r), .c(ext), .s(row_s), .co(row_co));
  assign total = {1'b0, sum_r} + {1'b0, carry_r};
  assign bus.in_ready = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum = out_sum_r;
  assign bus.out_of = out_of_r;
  assign bus.out_count = out_count_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      sum_r <= '0;
      carry_r <= '0;
      sticky_of <= 1'b0;
      cnt_r <= '0;
      out_sum_r <= '0;
      out_of_r <= 1'b0;
      out_count_r <= '0;
      in_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (bus.in_valid) begin
          sum_r <= row_s;
          // carry weight moves up one bit; the top carry falls off and is only remembered as overflow
          carry_r <= {row_co[ACC_WIDTH-2:0], 1'b0};
          sticky_of <= sticky_of | row_co[ACC_WIDTH-1];
          cnt_r <= &cnt_r ? cnt_r : cnt_r + CNT_WIDTH'(1);
          if (bus.in_last) begin
            state <= RESOLVE;
            in_ready_r <= 1'b0;
          end
        end
        RESOLVE: begin
          out_sum_r <= total[ACC_WIDTH-1:0];
          out_of_r <= sticky_of | total[ACC_WIDTH];
          out_count_r <= cnt_r;
          out_valid_r <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          sum_r <= '0;
          carry_r <= '0;
          sticky_of <= 1'b0;
          cnt_r <= '0;
          out_valid_r <= 1'b0;
          in_ready_r <= 1'b1;
          state <= ACCUM;
        end
        default: begin
          state <= ACCUM;
          in_ready_r <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: directed frames with a result scoreboard drained by an output monitor
module tb_csa_accumulator;
  typedef struct {
    logic [23:0] sum;
    logic of;
    logic [7:0] count;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  csa_if #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus ();
  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [23:0] s, input logic o, input logic [7:0] c);
    exp_t e;
    e.sum = s;
    e.of = o;
    e.count = c;
    q.push_back(e);
  endtask
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(bus.in_ready && q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(n), 0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_result", 32'(bus.out_sum), 32'hFFFFFFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_sum", 32'(bus.out_sum), 32'(e.sum));
        chk("out_of", 32'(bus.out_of), 32'(e.of));
        chk("out_count", 32'(bus.out_count), 32'(e.count));
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sum", 32'(bus.out_sum), 0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    @(negedge clk);
    rst = 1'b0;
    push(24'h000006, 1'b0, 8'd3);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    chk("lat_resolve_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_hold_valid", 32'(bus.out_valid), 1);
    wait_idle();
    push(24'hFFFF00, 1'b0, 8'd255);
    for (int i = 0; i < 256; i++) send(16'hFFFF, i == 255);
    wait_idle();
    push(24'h00FEFF, 1'b1, 8'd255);
    for (int i = 0; i < 257; i++) send(16'hFFFF, i == 256);
    wait_idle();
    push(24'h00ABCD, 1'b0, 8'd1);
    send(16'hABCD, 1'b1);
    wait_idle();
    bus.out_ready = 1'b0;
    push(24'h002222, 1'b0, 8'd1);
    push(24'h001111, 1'b0, 8'd1);
    send(16'h2222, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1111;
    bus.in_last = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      chk("hold_sum", 32'(bus.out_sum), 32'h002222);
    end
    bus.out_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("reaccept_timeout", 32'(n), 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    wait_idle();
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_sum", 32'(bus.out_sum), 0);
    chk("midrst_out_of", 32'(bus.out_of), 0);
    chk("midrst_out_count", 32'(bus.out_count), 0);
    @(negedge clk);
    rst = 1'b0;
    push(24'h000005, 1'b0, 8'd1);
    send(16'h0005, 1'b1);
    wait_idle();
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Parametrised multi-operand accumulator built on carry-save (3:2) compression.
- Accepts a stream of unsigned operands framed by `in_last` and keeps a redundant sum/carry pair, so the per-operand critical path is one full-adder deep, independent of width.
- Resolves the pair with one carry-propagate add at frame end and presents the total with overflow and operand count.
- Sits between operand producers (e.g. partial-product generators) and consumers needing a binary result; it is the sequential, generalised successor to the fixed 16-bit three-operand CSA.

## Interface
- `WIDTH`, 16, operand width in bits.
- `ACC_WIDTH`, 24, accumulator/result width; must be ≥ `WIDTH`+1.
- `CNT_WIDTH`, 8, operand counter width.
- `clk` in 1, rising-edge clock.
- `rst` in 1, reset, asynchronous, active-high.
- `in_valid` in 1, operand valid.
- `in_ready` out 1, block accepts an operand.
- `in_data` in `WIDTH`, unsigned operand, zero-extended to `ACC_WIDTH`.
- `in_last` in 1, qualifies the final operand of a frame.
- `out_valid` out 1, result valid.
- `out_ready` in 1, consumer accepts the result.
- `out_sum` out `ACC_WIDTH`, frame total modulo 2^`ACC_WIDTH`.
- `out_of` out 1, true total ≥ 2^`ACC_WIDTH`.
- `out_count` out `CNT_WIDTH`, operands in frame, saturating at 2^`CNT_WIDTH`−1.

## Operation
- States: `ACCUM` (reset state), `RESOLVE`, `HOLD`.
- Registers: `sum_r`, `carry_r` (`ACC_WIDTH`, 0 at reset), `sticky_of`, `cnt_r`.
- `in_ready` = (state == `ACCUM`); `out_valid` = (state == `HOLD`).
- ACCUM, on an input handshake (`in_valid` & `in_ready`):
  - compress `sum_r`, `carry_r` and the zero-extended operand through one 3:2 row;
  - `sum_r` ← row sum;
  - `carry_r` ← row carry shifted left 1, with bit 0 = 0;
  - the row carry out of bit `ACC_WIDTH`−1 is dropped and ORed into `sticky_of`;
  - `cnt_r` increments, saturating.
  - If `in_last` is also set, go to `RESOLVE`.
- RESOLVE (one cycle):
  - `out_sum` ← `sum_r` + `carry_r` (low `ACC_WIDTH` bits);
  - `out_of` ← `sticky_of` | carry-out of that add;
  - `out_count` ← `cnt_r`;
  - go to `HOLD`.
- HOLD: outputs stable until `out_valid` & `out_ready`. On that handshake, clear `sum_r`, `carry_r`, `sticky_of` and `cnt_r`, and go to `ACCUM`.
- `in_valid` outside `ACCUM` is ignored and nothing is consumed; `in_last` without `in_valid` is ignored.
- A frame always has ≥1 operand; a single-operand frame yields that operand.
- Reset at any time, including mid-frame or in `HOLD`:
  - immediately returns to `ACCUM` and discards partial state;
  - `out_valid`, `out_sum`, `out_of`, `out_count` = 0;
  - `in_ready` = 1 from reset.

## Timing
- Per accepted operand: throughput 1/cycle; no bubbles within a frame.
- Latency: last operand accepted at edge k → `out_valid` = 1 after edge k+1.
- `in_ready` low from edge k until the edge after the output handshake.
- Output handshake at edge m → `in_ready` = 1 and `out_valid` = 0 after edge m; the next frame's first operand can be accepted at edge m+1.
- No combinational path from `in_valid`/`in_data` or `out_ready` to any output.
- Critical path: the 3:2 row is one full adder deep; the `ACC_WIDTH` carry-propagate add sits only in `RESOLVE`.

## Structure
- `csa_pkg`: state enum (`ACCUM`, `RESOLVE`, `HOLD`); default-width localparams.
- Sub-module `csa_row #(W)`: purely combinational, `W` existing `full_adder` instances.
  - Inputs: `a`, `b`, `c`. Outputs: `s[W]`, `co[W]` (unshifted).
  - The shifting and dropped-MSB handling stay in `csa_accumulator`.
- The final add is a plain `+` in the parent.

## Test plan
- Frame 0x0001, 0x0002, 0x0003 (last) → `out_sum`=0x000006, `out_of`=0, `out_count`=3, `out_valid` one cycle after the last accept.
- 256 × 0xFFFF with last on the 256th → `out_sum`=0xFFFF00, `out_of`=0, `out_count`=255 (saturated).
- 257 × 0xFFFF → `out_sum`=0x00FEFF, `out_of`=1, `out_count`=255.
- Single 0xABCD with last → `out_sum`=0x00ABCD, `out_count`=1.
- Hold `out_ready` low 5 cycles with `in_valid`=1 and data 0x1111:
  - outputs are stable and `in_ready`=0;
  - after the handshake the next frame starts clean (0x1111 alone → `out_sum`=0x001111).
- Assert `rst` after 2 operands of a frame, then send 0x0005 (last) → `out_sum`=0x000005, `out_count`=1; all outputs are 0 while `rst` is high.
